// File: rtl/see_campaign_ctrl.sv
// see_campaign_ctrl
//
// Sequencer for single-event-upset injection campaigns. Walks a one-hot upset
// target across the bits and instances of one selected injection group, with a
// programmable quiet delay before each upset and an observation window after
// it. Inside the window the core's detection flag is sampled and each upset is
// classified as detected or missed.
//
// Ports
//   s_clk_i          clock, rising edge
//   s_reset_i        synchronous active-high reset, overrides everything
//   s_start_i        start a campaign (only from IDLE/DONE, ignored if count == 0)
//   s_stop_i         abort the running campaign
//   s_group_i        target group index, latched at start
//   s_delay_i        quiet cycles before each upset, latched at start
//   s_window_i       observation cycles after each upset, latched at start
//   s_count_i        number of upsets in the campaign, latched at start
//   s_detect_i       core error/correction flag, only looked at in WINDOW
//   s_group_o        one-hot enable of the latched group
//   s_upset_o        per-instance force vectors, at most one bit set overall
//   s_busy_o         campaign in progress (DELAY/INJECT/WINDOW)
//   s_done_o         campaign finished or aborted
//   s_inj_cnt_o      upsets injected (saturating)
//   s_det_cnt_o      upsets detected (saturating)
//   s_miss_cnt_o     upsets missed (saturating)
//
// Every output is driven straight from a register.

module see_campaign_ctrl #(
    parameter int unsigned W      = 32,
    parameter int unsigned N      = 3,
    parameter int unsigned GROUPS = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       s_clk_i,
    input  logic                       s_reset_i,
    input  logic                       s_start_i,
    input  logic                       s_stop_i,
    input  logic [$clog2(GROUPS)-1:0]  s_group_i,
    input  logic [CNT_W-1:0]           s_delay_i,
    input  logic [CNT_W-1:0]           s_window_i,
    input  logic [CNT_W-1:0]           s_count_i,
    input  logic                       s_detect_i,
    output logic [GROUPS-1:0]          s_group_o,
    output logic [W-1:0]               s_upset_o [N],
    output logic                       s_busy_o,
    output logic                       s_done_o,
    output logic [CNT_W-1:0]           s_inj_cnt_o,
    output logic [CNT_W-1:0]           s_det_cnt_o,
    output logic [CNT_W-1:0]           s_miss_cnt_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StInject,
        StWindow,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Campaign parameters captured at start.
    logic [CNT_W-1:0]  delay_q, delay_d;
    logic [CNT_W-1:0]  window_q, window_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Shared down-counter: delay in DELAY, window length in WINDOW.
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [IW-1:0]     inst_q, inst_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              flag_q, flag_d;

    logic [GROUPS-1:0] group_q, group_d;
    logic [W-1:0]      upset_q [N];
    logic [W-1:0]      upset_d [N];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  inj_q, inj_d;
    logic [CNT_W-1:0]  det_q, det_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    logic start_ok;
    logic hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stop outranks start, so a simultaneous stop suppresses the start.
    assign start_ok = s_start_i && !s_stop_i && (s_count_i != '0);

    // This cycle's detect counts toward the classification made at the window end.
    assign hit = flag_q | s_detect_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) state_d = StDelay;
            end
            StDelay: begin
                if (s_stop_i)            state_d = StDone;
                else if (cnt_q == '0)    state_d = StInject;
            end
            StInject: begin
                state_d = s_stop_i ? StDone : StWindow;
            end
            StWindow: begin
                if (s_stop_i) begin
                    state_d = StDone;
                end else if (cnt_q == '0) begin
                    state_d = (inj_q == count_q) ? StDone : StDelay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        delay_d  = delay_q;
        window_d = window_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        inst_d   = inst_q;
        bit_d    = bit_q;
        flag_d   = flag_q;
        group_d  = group_q;
        inj_d    = inj_q;
        det_d    = det_q;
        miss_d   = miss_q;
        // The upset is a single-cycle pulse; only entry into INJECT raises it.
        for (int i = 0; i < N; i++) upset_d[i] = '0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    delay_d  = s_delay_i;
                    window_d = s_window_i;
                    count_d  = s_count_i;
                    cnt_d    = s_delay_i;
                    group_d  = GROUPS'(1) << s_group_i;
                    inst_d   = '0;
                    bit_d    = '0;
                    flag_d   = 1'b0;
                    inj_d    = '0;
                    det_d    = '0;
                    miss_d   = '0;
                end
            end
            StDelay: begin
                if (!s_stop_i) begin
                    if (cnt_q == '0) upset_d[inst_q][bit_q] = 1'b1;
                    else             cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StInject: begin
                inj_d  = sat_inc(inj_q);
                cnt_d  = window_q;
                flag_d = 1'b0;
                // An aborted injection never gets its window, so it counts as missed.
                if (s_stop_i) miss_d = sat_inc(miss_q);
            end
            StWindow: begin
                flag_d = hit;
                if (s_stop_i || cnt_q == '0) begin
                    if (hit) det_d  = sat_inc(det_q);
                    else     miss_d = sat_inc(miss_q);
                end
                if (!s_stop_i) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (inj_q != count_q) begin
                        cnt_d = delay_q;
                        if (bit_q == BW'(W - 1)) begin
                            bit_d  = '0;
                            inst_d = (inst_q == IW'(N - 1)) ? '0 : inst_q + IW'(1);
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase

        busy_d = (state_d == StDelay) || (state_d == StInject) || (state_d == StWindow);
        done_d = (state_d == StDone);
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            delay_q  <= '0;
            window_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            inst_q   <= '0;
            bit_q    <= '0;
            flag_q   <= 1'b0;
            group_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            inj_q    <= '0;
            det_q    <= '0;
            miss_q   <= '0;
            for (int i = 0; i < N; i++) upset_q[i] <= '0;
        end else begin
            delay_q  <= delay_d;
            window_q <= window_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            inst_q   <= inst_d;
            bit_q    <= bit_d;
            flag_q   <= flag_d;
            group_q  <= group_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            inj_q    <= inj_d;
            det_q    <= det_d;
            miss_q   <= miss_d;
            for (int i = 0; i < N; i++) upset_q[i] <= upset_d[i];
        end
    end

    assign s_group_o    = group_q;
    assign s_upset_o    = upset_q;
    assign s_busy_o     = busy_q;
    assign s_done_o     = done_q;
    assign s_inj_cnt_o  = inj_q;
    assign s_det_cnt_o  = det_q;
    assign s_miss_cnt_o = miss_q;

endmodule

// File: tb/tb_see_campaign_ctrl.sv
module tb_see_campaign_ctrl;

    localparam int unsigned W      = 4;
    localparam int unsigned N      = 3;
    localparam int unsigned GROUPS = 4;
    localparam int unsigned CNT_W  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic [1:0]       group;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] window;
    logic [CNT_W-1:0] count;
    logic             detect;
    logic [GROUPS-1:0] group_oh;
    logic [W-1:0]     upset [N];
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] inj_cnt;
    logic [CNT_W-1:0] det_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    see_campaign_ctrl #(
        .W      (W),
        .N      (N),
        .GROUPS (GROUPS),
        .CNT_W  (CNT_W)
    ) dut (
        .s_clk_i      (clk),
        .s_reset_i    (reset),
        .s_start_i    (start),
        .s_stop_i     (stop),
        .s_group_i    (group),
        .s_delay_i    (delay),
        .s_window_i   (window),
        .s_count_i    (count),
        .s_detect_i   (detect),
        .s_group_o    (group_oh),
        .s_upset_o    (upset),
        .s_busy_o     (busy),
        .s_done_o     (done),
        .s_inj_cnt_o  (inj_cnt),
        .s_det_cnt_o  (det_cnt),
        .s_miss_cnt_o (miss_cnt)
    );

    // Upset vectors flattened as {inst2, inst1, inst0}; target (inst, bit) is bit inst*W+bit.
    function automatic logic [N*W-1:0] flat();
        return {upset[2], upset[1], upset[0]};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns with start already released; the DUT is then in its first DELAY cycle.
    task automatic launch(input logic [1:0] g, input int d, input int w, input int c);
        group  = g;
        delay  = CNT_W'(d);
        window = CNT_W'(w);
        count  = CNT_W'(c);
        start  = 1'b1;
        step(1);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit && !done; i++) step(1);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        group  = '0;
        delay  = '0;
        window = '0;
        count  = '0;
        detect = 1'b0;

        // Reset state
        step(2);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_group", 32'(group_oh), 32'd0);
        chk("rst_upset", 32'(flat()), 32'd0);
        chk("rst_stats", {inj_cnt, det_cnt, miss_cnt}, 32'd0);

        // Reset in the middle of a window
        launch(2'd2, 2, 3, 5);
        step(3);
        chk("b_first_upset", 32'(flat()), 32'h1);
        chk("b_group", 32'(group_oh), 32'b0100);
        step(2);
        chk("b_inj_in_window", 32'(inj_cnt), 32'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("b_rst_outs", {busy, done, group_oh, flat()}, 32'd0);
        chk("b_rst_stats", {inj_cnt, det_cnt, miss_cnt}, 32'd0);
        step(4);
        chk("b_stays_idle", {busy, done, flat()}, 32'd0);

        // count=3 delay=2 window=3 group=1, detect tied high; period 8
        detect = 1'b1;
        launch(2'd1, 2, 3, 3);
        for (int i = 0; i < 3; i++) begin
            step(2);
            chk("c_quiet", 32'(flat()), 32'd0);
            step(1);
            chk("c_upset", 32'(flat()), 32'(1) << i);
            chk("c_group", 32'(group_oh), 32'b0010);
            step(5);
        end
        chk("c_done", {busy, done}, 32'b01);
        chk("c_inj", 32'(inj_cnt), 32'd3);
        chk("c_det", 32'(det_cnt), 32'd3);
        chk("c_miss", 32'(miss_cnt), 32'd0);
        chk("c_upset_done", 32'(flat()), 32'd0);
        chk("c_group_done", 32'(group_oh), 32'b0010);
        detect = 1'b0;

        // 13 upsets, delay=0 window=0; restart from DONE clears statistics
        launch(2'd3, 0, 0, 13);
        chk("d_cleared", {inj_cnt, det_cnt, miss_cnt}, 32'd0);
        for (int i = 0; i < 13; i++) begin
            step(1);
            chk("d_target", 32'(flat()), 32'(1) << (i % 12));
            step(1);
            if (i == 1) detect = 1'b1;
            step(1);
            detect = 1'b0;
        end
        chk("d_done", 32'(done), 32'd1);
        chk("d_inj", 32'(inj_cnt), 32'd13);
        chk("d_det", 32'(det_cnt), 32'd1);
        chk("d_miss", 32'(miss_cnt), 32'd12);
        chk("d_group", 32'(group_oh), 32'b1000);

        // Stop during the INJECT cycle of the second upset
        launch(2'd0, 1, 1, 10);
        step(7);
        chk("e_second_upset", 32'(flat()), 32'h2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("e_done", {busy, done}, 32'b01);
        chk("e_upset_off", 32'(flat()), 32'd0);
        chk("e_inj", 32'(inj_cnt), 32'd2);
        chk("e_det", 32'(det_cnt), 32'd0);
        chk("e_miss", 32'(miss_cnt), 32'd2);

        // count=0 start is ignored
        launch(2'd1, 0, 0, 0);
        step(2);
        chk("f_zero_start", {busy, done}, 32'b01);
        chk("f_zero_stats", 32'(inj_cnt), 32'd2);

        // Start while busy is ignored
        launch(2'd2, 3, 0, 4);
        step(1);
        group  = 2'd0;
        delay  = '0;
        count  = 4'd9;
        start  = 1'b1;
        step(1);
        start  = 1'b0;
        chk("f_busy_start", 32'(flat()), 32'd0);
        chk("f_busy_group", 32'(group_oh), 32'b0100);
        step(2);
        chk("f_busy_upset", 32'(flat()), 32'h1);

        // Start and stop together in DELAY
        step(2);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("f_startstop", {busy, done}, 32'b01);
        chk("f_ss_inj", 32'(inj_cnt), 32'd1);
        chk("f_ss_miss", 32'(miss_cnt), 32'd1);

        // Full-range campaign, restarted twice without reset
        detect = 1'b1;
        for (int r = 0; r < 3; r++) begin
            launch(2'd3, 0, 0, 15);
            chk("g_cleared", {inj_cnt, det_cnt, miss_cnt}, 32'd0);
            wait_done(60);
            chk("g_done", 32'(done), 32'd1);
            chk("g_inj", 32'(inj_cnt), 32'd15);
            chk("g_det", 32'(det_cnt), 32'd15);
            chk("g_miss", 32'(miss_cnt), 32'd0);
        end
        detect = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
